// File: rtl/fm_radio_pkg.sv
// Shared types and constants for the FM radio audio path.
package fm_radio_pkg;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MULT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Default de-emphasis filter constants (Q.10 fixed point)
    localparam int IIR_BITS = 10;
    localparam int IIR_B0   = 178;
    localparam int IIR_B1   = 178;
    localparam int IIR_Y1   = 666;

    // Wide enough for 2*DATA_WIDTH+1 bit sums with DATA_WIDTH up to 64
    localparam int DEQ_W = 129;
    typedef logic signed [DEQ_W-1:0] deq_t;

    // Arithmetic right shift: floor division by 2**bits
    function automatic deq_t dequantize(input deq_t value, input int bits);
        return value >>> bits;
    endfunction

endpackage

// File: rtl/iir_deemph.sv
// Single-pole IIR de-emphasis:
//   y[n] = DQ(B0*x[n] + B1*x[n-1]) + DQ(Y1*y[n-1])
// FIFO in, FIFO out, one sample in flight, 3-cycle read/multiply/write loop.
module iir_deemph
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = IIR_BITS,
    parameter int B0         = IIR_B0,
    parameter int B1         = IIR_B1,
    parameter int Y1         = IIR_Y1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_in_empty,
    output logic                  x_in_rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + 1;

    localparam logic signed [DATA_WIDTH-1:0] B0_S = DATA_WIDTH'(B0);
    localparam logic signed [DATA_WIDTH-1:0] B1_S = DATA_WIDTH'(B1);
    localparam logic signed [DATA_WIDTH-1:0] Y1_S = DATA_WIDTH'(Y1);

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   x_reg;
    logic signed [DATA_WIDTH-1:0]   x_prev;
    logic signed [DATA_WIDTH-1:0]   y_prev;
    logic signed [PW-1:0]           p0;
    logic signed [PW-1:0]           p1;
    logic signed [PW-1:0]           p2;

    logic signed [SW-1:0]           sum01;
    deq_t                           deq_sum;
    logic signed [DATA_WIDTH-1:0]   result;

    // Combine the registered products; result wraps to DATA_WIDTH bits
    always_comb begin
        sum01   = SW'(p0) + SW'(p1);
        deq_sum = dequantize(DEQ_W'(sum01), BITS) + dequantize(DEQ_W'(p2), BITS);
        result  = deq_sum[DATA_WIDTH-1:0];
    end

    // Handshakes decoded from state; reset suppresses any pop or write in its cycle
    always_comb begin
        x_in_rd_en = !reset && (state == S_READ) && !x_in_empty;
        out_wr_en  = !reset && (state == S_WRITE) && !out_full;
        dout       = out_wr_en ? result : '0;
    end

    // Control FSM and datapath registers; history advances only on an accepted write
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_READ;
            x_reg  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            p0     <= '0;
            p1     <= '0;
            p2     <= '0;
        end else begin
            case (state)
                S_READ: begin
                    if (!x_in_empty) begin
                        x_reg <= signed'(x_in);
                        state <= S_MULT;
                    end
                end
                S_MULT: begin
                    p0    <= PW'(B0_S) * PW'(x_reg);
                    p1    <= PW'(B1_S) * PW'(x_prev);
                    p2    <= PW'(Y1_S) * PW'(y_prev);
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!out_full) begin
                        x_prev <= x_reg;
                        y_prev <= result;
                        state  <= S_READ;
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end

endmodule
